// File: rtl/txbf_ch0.sv
// Per-channel transmit beamformer: LUT-driven focusing delay followed by a bipolar
// pulse train for the HV pulser, with tx_en/tx_busy/tx_done status.

// Output invariants that must hold whenever the channel is out of reset
module txbf_ch0_chk (
   input logic clk,
   input logic rst,
   input logic pulse_p,
   input logic pulse_n,
   input logic tx_en,
   input logic tx_busy,
   input logic tx_done
);

   a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(pulse_p && pulse_n));
   a_done_strobe: assert property (@(posedge clk) disable iff (rst) tx_done |=> !tx_done);
   a_en_busy: assert property (@(posedge clk) disable iff (rst) tx_en |-> tx_busy);

endmodule

module txbf_ch0 #(
   parameter int ADDR_WD = 7,
   parameter int DLY_WD  = 12,
   parameter int NCYC_WD = 4,
   parameter int HP_WD   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_WD-1:0] lut_addr,
   input  logic [DLY_WD-1:0]  lut_din,
   input  logic               lut_we,
   input  logic               tx_start,
   input  logic [ADDR_WD-1:0] line_addr,
   input  logic [NCYC_WD-1:0] n_cycles,
   input  logic [HP_WD-1:0]   half_period,
   input  logic               tx_abort,
   output logic               pulse_p,
   output logic               pulse_n,
   output logic               tx_en,
   output logic               tx_busy,
   output logic               tx_done
);

   localparam logic [HP_WD-1:0]   HP_ONE   = {{(HP_WD-1){1'b0}}, 1'b1};
   localparam logic [DLY_WD-1:0]  DLY_ONE  = {{(DLY_WD-1){1'b0}}, 1'b1};
   localparam logic [NCYC_WD-1:0] NCYC_ONE = {{(NCYC_WD-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DELAY = 3'd2,
      S_PULSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_r;
   logic [DLY_WD-1:0]  lut_r [0:(2**ADDR_WD)-1];
   logic [DLY_WD-1:0]  lut_rd_s;
   logic [ADDR_WD-1:0] line_r;
   logic [NCYC_WD-1:0] ncyc_r;
   logic [NCYC_WD-1:0] cyc_cnt_r;
   logic [HP_WD-1:0]   hp_r;
   logic [HP_WD-1:0]   hp_cnt_r;
   logic [DLY_WD-1:0]  dly_cnt_r;
   logic               phase_r;
   logic               pulse_p_r;
   logic               pulse_n_r;
   logic               tx_en_r;
   logic               tx_busy_r;
   logic               tx_done_r;

   // Host-writable delay table; deliberately untouched by rst
   always_ff @(posedge clk) begin
      if (lut_we) begin
         lut_r[lut_addr] <= lut_din;
      end
   end

   assign lut_rd_s = lut_r[line_r];

   // Transmit sequencer; outputs are registered from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         line_r    <= '0;
         ncyc_r    <= '0;
         cyc_cnt_r <= '0;
         hp_r      <= HP_ONE;
         hp_cnt_r  <= HP_ONE;
         dly_cnt_r <= '0;
         phase_r   <= 1'b0;
         pulse_p_r <= 1'b0;
         pulse_n_r <= 1'b0;
         tx_en_r   <= 1'b0;
         tx_busy_r <= 1'b0;
         tx_done_r <= 1'b0;
      end else if (tx_abort && (state_r != S_IDLE)) begin
         state_r   <= S_IDLE;
         pulse_p_r <= 1'b0;
         pulse_n_r <= 1'b0;
         tx_en_r   <= 1'b0;
         tx_busy_r <= 1'b0;
         tx_done_r <= 1'b0;
      end else begin
         tx_done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               pulse_p_r <= 1'b0;
               pulse_n_r <= 1'b0;
               if (tx_start && !tx_abort) begin
                  line_r    <= line_addr;
                  ncyc_r    <= n_cycles;
                  hp_r      <= (half_period == '0) ? HP_ONE : half_period;
                  state_r   <= S_LOAD;
                  tx_en_r   <= 1'b1;
                  tx_busy_r <= 1'b1;
               end else begin
                  tx_en_r   <= 1'b0;
                  tx_busy_r <= 1'b0;
               end
            end
            S_LOAD: begin
               dly_cnt_r <= lut_rd_s;
               if (lut_rd_s != '0) begin
                  state_r <= S_DELAY;
               end else if (ncyc_r == '0) begin
                  state_r   <= S_DONE;
                  tx_en_r   <= 1'b0;
                  tx_done_r <= 1'b1;
               end else begin
                  state_r   <= S_PULSE;
                  pulse_p_r <= 1'b1;
                  pulse_n_r <= 1'b0;
                  phase_r   <= 1'b0;
                  hp_cnt_r  <= HP_ONE;
                  cyc_cnt_r <= NCYC_ONE;
               end
            end
            S_DELAY: begin
               // Counter was loaded nonzero, so reaching one marks the last delay clock
               if (dly_cnt_r != DLY_ONE) begin
                  dly_cnt_r <= dly_cnt_r - DLY_ONE;
               end else if (ncyc_r == '0) begin
                  state_r   <= S_DONE;
                  tx_en_r   <= 1'b0;
                  tx_done_r <= 1'b1;
               end else begin
                  state_r   <= S_PULSE;
                  pulse_p_r <= 1'b1;
                  pulse_n_r <= 1'b0;
                  phase_r   <= 1'b0;
                  hp_cnt_r  <= HP_ONE;
                  cyc_cnt_r <= NCYC_ONE;
               end
            end
            S_PULSE: begin
               if (hp_cnt_r != hp_r) begin
                  hp_cnt_r <= hp_cnt_r + HP_ONE;
               end else if (!phase_r) begin
                  phase_r   <= 1'b1;
                  pulse_p_r <= 1'b0;
                  pulse_n_r <= 1'b1;
                  hp_cnt_r  <= HP_ONE;
               end else if (cyc_cnt_r == ncyc_r) begin
                  state_r   <= S_DONE;
                  pulse_p_r <= 1'b0;
                  pulse_n_r <= 1'b0;
                  tx_en_r   <= 1'b0;
                  tx_done_r <= 1'b1;
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + NCYC_ONE;
                  phase_r   <= 1'b0;
                  pulse_p_r <= 1'b1;
                  pulse_n_r <= 1'b0;
                  hp_cnt_r  <= HP_ONE;
               end
            end
            S_DONE: begin
               state_r   <= S_IDLE;
               tx_busy_r <= 1'b0;
            end
            default: begin
               state_r   <= S_IDLE;
               pulse_p_r <= 1'b0;
               pulse_n_r <= 1'b0;
               tx_en_r   <= 1'b0;
               tx_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_p = pulse_p_r;
   assign pulse_n = pulse_n_r;
   assign tx_en   = tx_en_r;
   assign tx_busy = tx_busy_r;
   assign tx_done = tx_done_r;

   txbf_ch0_chk u_chk (
      .clk     (clk),
      .rst     (rst),
      .pulse_p (pulse_p_r),
      .pulse_n (pulse_n_r),
      .tx_en   (tx_en_r),
      .tx_busy (tx_busy_r),
      .tx_done (tx_done_r)
   );

endmodule

// File: tb/tb_txbf_ch0.sv
// Bench for txbf_ch0: timing-formula reference model compared every cycle,
// plus directed fires with hand-computed output masks.
module tb_txbf_ch0;

   localparam int AW = 7;
   localparam int DW = 12;
   localparam int NW = 4;
   localparam int HW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] lut_addr;
   logic [DW-1:0] lut_din;
   logic          lut_we;
   logic          tx_start;
   logic [AW-1:0] line_addr;
   logic [NW-1:0] n_cycles;
   logic [HW-1:0] half_period;
   logic          tx_abort;
   logic          pulse_p, pulse_n, tx_en, tx_busy, tx_done;

   int total = 0;
   int bad   = 0;

   txbf_ch0 #(.ADDR_WD(AW), .DLY_WD(DW), .NCYC_WD(NW), .HP_WD(HW)) dut (
      .clk(clk), .rst(rst), .lut_addr(lut_addr), .lut_din(lut_din), .lut_we(lut_we),
      .tx_start(tx_start), .line_addr(line_addr), .n_cycles(n_cycles),
      .half_period(half_period), .tx_abort(tx_abort), .pulse_p(pulse_p),
      .pulse_n(pulse_n), .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   // Reference model: one fire described by T, d, N, H and an abort cycle
   int mlut [0:127];
   int cyc   = 0;
   bit m_act = 1'b0;
   int m_t, m_d, m_n, m_h, m_line;
   int m_a   = 32'h7fffffff;

   function automatic bit m_idle(int c);
      if (!m_act || c > m_a) return 1'b1;
      if (c == m_t + 1) return 1'b0;
      return (c > m_t + 2 + m_d + 2 * m_h * m_n);
   endfunction

   // {pulse_p, pulse_n, tx_en, tx_busy, tx_done} required in cycle c
   function automatic logic [4:0] m_exp(int c);
      int k, e, j;
      if (!m_act || c > m_a) return 5'b00000;
      k = c - m_t;
      if (k < 1) return 5'b00000;
      if (k == 1) return 5'b00110;
      e = 2 + m_d + 2 * m_h * m_n;
      if (k > e) return 5'b00000;
      if (k == e) return 5'b00011;
      if (k < 2 + m_d) return 5'b00110;
      j = k - 2 - m_d;
      if (((j / m_h) % 2) == 0) return 5'b10110;
      return 5'b01110;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_act = 1'b0;
      end else begin
         if (m_act && cyc == m_t + 1) m_d = mlut[m_line];
         if (!m_idle(cyc) && tx_abort) begin
            m_a = cyc;
         end else if (m_idle(cyc) && tx_start && !tx_abort) begin
            m_act  = 1'b1;
            m_t    = cyc;
            m_line = int'(line_addr);
            m_n    = int'(n_cycles);
            m_h    = (half_period == 5'd0) ? 1 : int'(half_period);
            m_d    = 0;
            m_a    = 32'h7fffffff;
         end
      end
      if (lut_we) mlut[lut_addr] = int'(lut_din);
      cyc++;
   end

   initial forever begin
      logic [4:0] got, want;
      @(negedge clk);
      if (cyc >= 1) begin
         got  = {pulse_p, pulse_n, tx_en, tx_busy, tx_done};
         want = m_exp(cyc);
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL model cyc=%0d {p,n,en,busy,done} got=%b want=%b", cyc, got, want);
         end
         total++;
         if (pulse_p && pulse_n) begin
            bad++;
            $display("FAIL overlap cyc=%0d pulse_p=%b pulse_n=%b want not both 1", cyc, pulse_p, pulse_n);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic lut_write(input int a, input int v);
      lut_we   = 1'b1;
      lut_addr = AW'(a);
      lut_din  = DW'(v);
      step();
      lut_we   = 1'b0;
   endtask

   // Fire once and record each output over cycles T..T+31 as a bit mask
   task automatic fire_sample(input int line, input int n, input int h,
                              output logic [31:0] pm, output logic [31:0] nm,
                              output logic [31:0] em, output logic [31:0] dm);
      tx_start    = 1'b1;
      line_addr   = AW'(line);
      n_cycles    = NW'(n);
      half_period = HW'(h);
      step();
      tx_start = 1'b0;
      pm = '0; nm = '0; em = '0; dm = '0;
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         pm[k] = pulse_p;
         nm[k] = pulse_n;
         em[k] = tx_en;
         dm[k] = tx_done;
      end
      step();
   endtask

   initial begin
      logic [31:0] pm, nm, em, dm;
      rst = 1'b1; tx_start = 1'b1; line_addr = '0; n_cycles = 4'd1; half_period = 5'd1;
      tx_abort = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_din = '0;
      repeat (3) step();
      rst = 1'b0; tx_start = 1'b0;
      step();
      @(negedge clk);
      chk("idle_after_reset", {27'd0, pulse_p, pulse_n, tx_en, tx_busy, tx_done}, 32'd0);
      step();

      lut_write(5, 10);
      lut_write(0, 0);
      fire_sample(5, 2, 3, pm, nm, em, dm);
      chk("basic_pulse_p", pm, 32'h001C7000);
      chk("basic_pulse_n", nm, 32'h00E38000);
      chk("basic_tx_en", em, 32'h00FFFFFE);
      chk("basic_tx_done", dm, 32'h01000000);

      fire_sample(0, 1, 0, pm, nm, em, dm);
      chk("zero_d_pulse_p", pm, 32'h00000004);
      chk("zero_d_pulse_n", nm, 32'h00000008);
      chk("zero_d_tx_done", dm, 32'h00000010);
      chk("zero_d_tx_en", em, 32'h0000000E);

      fire_sample(0, 0, 5, pm, nm, em, dm);
      chk("zero_n_pulses", pm | nm, 32'h00000000);
      chk("zero_n_tx_en", em, 32'h00000002);
      chk("zero_n_tx_done", dm, 32'h00000004);

      // Start and LUT rewrite during DELAY of a d=20 fire
      lut_write(5, 20);
      tx_start = 1'b1; line_addr = 7'd5; n_cycles = 4'd1; half_period = 5'd2;
      step();
      tx_start = 1'b0;
      repeat (4) step();
      tx_start = 1'b1; n_cycles = 4'd3; lut_we = 1'b1; lut_addr = 7'd5; lut_din = 12'd4;
      step();
      tx_start = 1'b0; lut_we = 1'b0;
      repeat (40) step();
      fire_sample(5, 1, 1, pm, nm, em, dm);
      chk("updated_lut_pulse_p", pm, 32'h00000040);
      chk("updated_lut_tx_done", dm, 32'h00000100);

      // Abort in the second PULSE cycle of a d=0 fire
      tx_start = 1'b1; line_addr = 7'd0; n_cycles = 4'd3; half_period = 5'd2;
      step();
      tx_start = 1'b0;
      step();
      step();
      tx_abort = 1'b1;
      step();
      tx_abort = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {27'd0, pulse_p, pulse_n, tx_en, tx_busy, tx_done}, 32'd0);
      repeat (10) step();
      fire_sample(0, 1, 1, pm, nm, em, dm);
      chk("after_abort_pulse_p", pm, 32'h00000004);
      chk("after_abort_tx_done", dm, 32'h00000010);

      // Randomized traffic over all lines
      for (int i = 0; i < 128; i++) begin
         lut_write(i, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 40));
      end
      for (int i = 0; i < 9000; i++) begin
         tx_start    = ($urandom_range(0, 5) == 0);
         line_addr   = AW'($urandom_range(0, 127));
         n_cycles    = NW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
         half_period = HW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4));
         tx_abort    = ($urandom_range(0, 299) == 0);
         lut_we      = ($urandom_range(0, 19) == 0);
         lut_addr    = AW'($urandom_range(0, 127));
         lut_din     = DW'($urandom_range(0, 60));
         step();
      end
      tx_start = 1'b0; tx_abort = 1'b0; lut_we = 1'b0;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/txbf_ch0.md
# txbf_ch0

Per-channel transmit beamforming unit: the transmit-side counterpart of the receive DBF channel. On a scan-line fire command it looks up that line's transmit focusing delay in an internal, host-writable delay LUT, waits that many clocks, then drives a bipolar pulse train (pulse_p / pulse_n) to the high-voltage pulser. It also generates tx_en, whose inverse gates the receive coarse-delay input valid on the same channel.

## Interface
Parameters:
- ADDR_WD, 7: scan-line address width; the LUT has 2**ADDR_WD entries.
- DLY_WD, 12: width of each delay entry in clocks (40 MHz, 25 ns step).
- NCYC_WD, 4: width of the pulse-cycle count.
- HP_WD, 5: width of the half-period length in clocks.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  reset; synchronous and active-high (one clock domain, all logic on the rising edge of clk).
- lut_addr  in  ADDR_WD  LUT write address.
- lut_din  in  DLY_WD  LUT write data (delay in clocks).
- lut_we  in  1  LUT write enable; writes lut_din to lut_addr on that edge.
- tx_start  in  1  fire pulse; sampled only in IDLE.
- line_addr  in  ADDR_WD  scan line to fire; sampled with tx_start.
- n_cycles  in  NCYC_WD  number of bipolar cycles; sampled with tx_start.
- half_period  in  HP_WD  clocks per half-cycle; sampled with tx_start; 0 is treated as 1.
- tx_abort  in  1  immediate stop.
- pulse_p  out  1  positive pulser drive.
- pulse_n  out  1  negative pulser drive.
- tx_en  out  1  transmit window active.
- tx_busy  out  1  unit not in IDLE.
- tx_done  out  1  one-cycle completion strobe.

## Operation
- LUT: 2**ADDR_WD x DLY_WD register array with a synchronous write port and a synchronous read in LOAD. Its contents are not cleared by rst.
- FSM states: IDLE, LOAD, DELAY, PULSE, DONE.
- IDLE: when tx_start=1, latch line_addr, n_cycles, and H=max(half_period,1), then go to LOAD.
- LOAD: read LUT[line_addr] into the delay counter. Go to DELAY if the value is nonzero. Otherwise go to PULSE, or to DONE if n_cycles=0.
- DELAY: decrement the counter each cycle. When it expires, go to PULSE, or to DONE if n_cycles=0.
- PULSE: each cycle is pulse_p high for H clocks, then pulse_n high for H clocks. Repeat n_cycles times, then go to DONE.
- DONE: tx_done=1 for one cycle, then go to IDLE.
- Outputs are registered. pulse_p and pulse_n are never high in the same cycle.
- tx_en is high in LOAD, DELAY and PULSE.
- tx_busy is high in every state except IDLE.
- tx_start outside IDLE is ignored; it is not queued.
- tx_abort has priority over everything except rst. In any non-IDLE state it forces IDLE on the next edge, drives all outputs low from that edge, and produces no tx_done.
- A LUT write during a transmit takes effect on the next fire, because the value is captured in LOAD. A write on the same edge as the LOAD read returns the old value.
- rst: state goes to IDLE; pulse_p, pulse_n, tx_en, tx_busy and tx_done all go to 0. rst applied mid-transmit behaves the same as abort.

## Timing
- Let T be the cycle in which tx_start=1 is sampled in IDLE, d = LUT[line_addr], and N = n_cycles.
- LOAD occupies T+1; tx_en and tx_busy rise at T+1.
- DELAY occupies T+2 … T+1+d (absent if d=0).
- pulse_p is high in cycles T+2+d … T+1+d+H, and pulse_n in the following H cycles. The pattern repeats N times, ending at T+1+d+2HN.
- tx_en falls and tx_done is high at T+2+d+2HN; tx_busy falls one cycle later.
- Earliest next accepted tx_start is T+3+d+2HN.
- Fire-to-first-pulse latency is d+2 clocks. Delay wrap does not occur: the counter is DLY_WD wide and loaded, never incremented.

## Test plan
- Reset and idle: assert rst for 3 cycles with tx_start=1 → all outputs stay 0 throughout; state is IDLE after release.
- Basic fire: write LUT[5]=10, then tx_start at T with line_addr=5, n_cycles=2, half_period=3 → pulse_p high at T+12..T+14 and T+18..T+20, pulse_n high at T+15..T+17 and T+21..T+23, tx_en high T+1..T+23, tx_done high only at T+24.
- Zero cases: LUT[0]=0 with n_cycles=1, half_period=0 → pulse_p at T+2, pulse_n at T+3, tx_done at T+4. With n_cycles=0 → no pulses, tx_en high at T+1 only, tx_done at T+2.
- Busy and LUT update: during the DELAY of a d=20 fire, pulse tx_start and write LUT[5]=4 → the current fire is unchanged and there is no second fire. The next fire on line 5 gives its first pulse_p at T'+6.
- Abort: tx_abort in the 2nd PULSE cycle → all outputs 0 on the next edge, no tx_done; a subsequent tx_start is accepted normally.
- Randomized lines 0–127 with random d, N and H → every fire matches the reference timing formula, and pulse_p and pulse_n are never both high.
